afft_seq: RTL and testbench
===========================

AFFT_SEQ -- requirements
Module: afft_seq

Interface
REQ-001 SHALL have parameter LOG2N, default 3, log2 of FFT length N (legal 2..10).
REQ-002 SHALL have parameter BTF_LAT, default 3, butterfly pipeline latency in cycles (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one FFT run; sampled only in IDLE.
REQ-006 SHALL have port inv  input  1  inverse-transform select; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high from first issue cycle through last write cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the final write.
REQ-009 SHALL have port stage  output  4  current stage index 0..LOG2N-1.
REQ-010 SHALL have port rd_en  output  1  data RAM read strobe, one butterfly pair per cycle.
REQ-011 SHALL have ports rd_addr0, rd_addr1  output  LOG2N  upper/lower butterfly operand addresses.
REQ-012 SHALL have port tw_addr  output  LOG2N-1  twiddle ROM index, valid with rd_en.
REQ-013 SHALL have port tw_conj  output  1  conjugate twiddle (equals captured inv), valid with rd_en.
REQ-014 SHALL have port bf_valid  output  1  rd_en delayed 1 cycle (RAM read latency 1); butterfly input valid.
REQ-015 SHALL have port wr_en  output  1  data RAM write strobe for butterfly results.
REQ-016 SHALL have ports wr_addr0, wr_addr1  output  LOG2N  write-back addresses (in-place).

Function
REQ-017 SHALL implement in-place radix-2 DIF sequencing: LOG2N stages, N/2 butterflies per stage.
REQ-018 SHALL, in stage s, use span = N>>(s+1), groups = 1<<s; group g, step j (0..span-1): rd_addr0 = 2*span*g + j, rd_addr1 = rd_addr0 + span, tw_addr = j<<s.
REQ-019 SHALL issue order: j increments fastest, then g; one issue per cycle with no bubbles within a stage.
REQ-020 SHALL implement states IDLE, RUN, DRAIN, FIN.
REQ-021 SHALL transition IDLE->RUN on start; rd_en first high the cycle after start is sampled.
REQ-022 SHALL transition RUN->DRAIN after the last issue of a stage; rd_en low in DRAIN.
REQ-023 SHALL, in DRAIN, wait until the stage's last wr_en cycle, then go to RUN (next stage) or FIN (last stage).
REQ-024 SHALL generate wr_en/wr_addr0/wr_addr1 as rd_en/rd_addr0/rd_addr1 delayed exactly 1+BTF_LAT cycles (shift-register pipeline).
REQ-025 SHALL start the next stage's first read the cycle after the previous stage's last write (no read-after-write overlap); stage length = N/2+1+BTF_LAT cycles.
REQ-026 SHALL, in FIN, pulse done for one cycle with busy low, then return to IDLE.
REQ-027 SHALL ignore start while not in IDLE, including in the FIN cycle; inv changes after capture have no effect.
REQ-028 SHALL hold stage at the current stage through RUN and DRAIN; stage = 0 in IDLE.
REQ-029 SHALL hold all address outputs at 0 whenever their strobe is low.
REQ-030 SHALL count with widths sized from LOG2N; no counter wrap into out-of-range addresses.

Reset
REQ-031 SHALL, on rst high at any clock edge (including mid-run), enter IDLE and zero all outputs and pipeline stages next cycle; no wr_en issued after reset from pre-reset reads.
REQ-032 SHALL give rst priority over start in the same cycle.

Verification
REQ-033 SHALL cover N=8, BTF_LAT=3, start at cycle 0 -> reads (addr0,addr1,tw) stage0 (0,4,0)(1,5,1)(2,6,2)(3,7,3) cycles 1-4; stage1 (0,2,0)(1,3,2)(4,6,0)(5,7,2) cycles 9-12; stage2 (0,1,0)(2,3,0)(4,5,0)(6,7,0) cycles 17-20.
REQ-034 SHALL cover same run -> wr_en cycles 5-8, 13-16, 21-24 with addresses matching reads; busy high cycles 1-24; done pulse cycle 25 only.
REQ-035 SHALL cover inv=1 at start, inv=0 from cycle 2 -> tw_conj=1 on all 12 issues.
REQ-036 SHALL cover rst at cycle 10 of a run -> cycle 11 IDLE, all outputs 0, no wr_en until next start; fresh start yields full sequence of REQ-033.
REQ-037 SHALL cover start pulsed at cycles 5 and 25 -> both ignored; start at 26 accepted, rd_en at 27.
REQ-038 SHALL cover LOG2N=10, BTF_LAT=1 -> 5120 writes, each address written exactly once per stage, done at cycle 10*(512+2)+1.

Source files
------------

// File: rtl/afft_seq_if.sv
// Handshake and RAM/ROM strobe bundle for the in-place radix-2 FFT address sequencer.
// The sequencer uses the master view; the data path (or a bench) uses the slave view.
interface afft_seq_if #(
    parameter int LOG2N = 3
);
    logic             start;
    logic             inv;
    logic             busy;
    logic             done;
    logic [3:0]       stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr0;
    logic [LOG2N-1:0] rd_addr1;
    logic [LOG2N-2:0] tw_addr;
    logic             tw_conj;
    logic             bf_valid;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr0;
    logic [LOG2N-1:0] wr_addr1;

    modport master (
        input  start, inv,
        output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr, tw_conj,
               bf_valid, wr_en, wr_addr0, wr_addr1
    );

    modport slave (
        output start, inv,
        input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr, tw_conj,
               bf_valid, wr_en, wr_addr0, wr_addr1
    );
endinterface

// File: rtl/afft_seq.sv
// In-place radix-2 DIF FFT address sequencer: issues one butterfly read per cycle,
// replays it as a write 1+BTF_LAT cycles later, and drains each stage before the next.
module afft_seq #(
    parameter int LOG2N   = 3,
    parameter int BTF_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    afft_seq_if.master    bus
);
    localparam int CW = LOG2N - 1;
    localparam int TW = LOG2N - 1;
    localparam logic [CW-1:0]    CNT_LAST   = {CW{1'b1}};
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [LOG2N-1:0] ADDR_ONE   = LOG2N'(1);
    localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(BTF_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [3:0]       stage_q, stage_d;
    logic             inv_q, inv_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       stage_o_q, stage_o_d;
    logic             rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_addr0_q, rd_addr0_d;
    logic [LOG2N-1:0] rd_addr1_q, rd_addr1_d;
    logic [TW-1:0]    tw_addr_q, tw_addr_d;
    logic             tw_conj_q, tw_conj_d;

    logic [3:0]       sh_s;
    logic [LOG2N-1:0] k_s, span_s, j_s, a0_s;

    logic             pipe_en_q [BTF_LAT+1];
    logic [LOG2N-1:0] pipe_a0_q [BTF_LAT+1];
    logic [LOG2N-1:0] pipe_a1_q [BTF_LAT+1];

    // State register, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            dcnt_q     <= 4'd0;
            stage_q    <= 4'd0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stage_o_q  <= 4'd0;
            rd_en_q    <= 1'b0;
            rd_addr0_q <= {LOG2N{1'b0}};
            rd_addr1_q <= {LOG2N{1'b0}};
            tw_addr_q  <= {TW{1'b0}};
            tw_conj_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            stage_q    <= stage_d;
            inv_q      <= inv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            stage_o_q  <= stage_o_d;
            rd_en_q    <= rd_en_d;
            rd_addr0_q <= rd_addr0_d;
            rd_addr1_q <= rd_addr1_d;
            tw_addr_q  <= tw_addr_d;
            tw_conj_q  <= tw_conj_d;
        end
    end

    // Next-state: the issue counter covers one stage, the drain counter waits out the write lag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = {CW{1'b0}};
                    dcnt_d  = 4'd0;
                    stage_d = 4'd0;
                    inv_d   = bus.inv;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DRAIN;
                    dcnt_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (dcnt_q == DRAIN_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (stage_q == STAGE_LAST) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 4'd1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs for the coming cycle; an address is the issue index with a 0 inserted at bit (LOG2N-1-stage)
    always_comb begin
        busy_d    = (state_d == RUN) || (state_d == DRAIN);
        done_d    = (state_d == FIN);
        rd_en_d   = (state_d == RUN);
        sh_s      = STAGE_LAST - stage_d;
        k_s       = {1'b0, cnt_d};
        span_s    = ADDR_ONE << sh_s;
        j_s       = k_s & (span_s - ADDR_ONE);
        a0_s      = ((k_s >> sh_s) << (sh_s + 4'd1)) | j_s;
        if (busy_d) begin
            stage_o_d = stage_d;
        end else begin
            stage_o_d = 4'd0;
        end
        if (rd_en_d) begin
            rd_addr0_d = a0_s;
            rd_addr1_d = a0_s | span_s;
            tw_addr_d  = TW'(j_s << stage_d);
            tw_conj_d  = inv_d;
        end else begin
            rd_addr0_d = {LOG2N{1'b0}};
            rd_addr1_d = {LOG2N{1'b0}};
            tw_addr_d  = {TW{1'b0}};
            tw_conj_d  = 1'b0;
        end
    end

    // Read-to-write delay line: slot 0 is the RAM read latency, the rest cover the butterfly
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= BTF_LAT; i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a0_q[i] <= {LOG2N{1'b0}};
                pipe_a1_q[i] <= {LOG2N{1'b0}};
            end
        end else begin
            pipe_en_q[0] <= rd_en_q;
            pipe_a0_q[0] <= rd_addr0_q;
            pipe_a1_q[0] <= rd_addr1_q;
            for (int i = 1; i <= BTF_LAT; i++) begin
                pipe_en_q[i] <= pipe_en_q[i-1];
                pipe_a0_q[i] <= pipe_a0_q[i-1];
                pipe_a1_q[i] <= pipe_a1_q[i-1];
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.stage    = stage_o_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr0 = rd_addr0_q;
    assign bus.rd_addr1 = rd_addr1_q;
    assign bus.tw_addr  = tw_addr_q;
    assign bus.tw_conj  = tw_conj_q;
    assign bus.bf_valid = pipe_en_q[0];
    assign bus.wr_en    = pipe_en_q[BTF_LAT];
    assign bus.wr_addr0 = pipe_a0_q[BTF_LAT];
    assign bus.wr_addr1 = pipe_a1_q[BTF_LAT];
endmodule

// File: tb/tb_afft_seq.sv
// Bench for afft_seq: fixed N=8 vectors, randomized runs against a stage/group/step
// model, mid-run reset, ignored starts, and a full N=1024 coverage run.
module tb_afft_seq;
    typedef struct {
        int busy; int done; int stage; int bfv;
        int rd_en; int a0; int a1; int tw; int conj;
        int wr_en; int w0; int w1;
    } exp_t;

    typedef struct {
        int cyc; int a0; int a1; int tw; int cj;
    } rec_t;

    typedef struct {
        int rc; int a0; int a1; int tw; int wc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    rec_t rdq[$];
    rec_t wrq[$];
    vec_t tbl[12];
    int   cov[10][1024];

    always #5 clk = ~clk;

    afft_seq_if #(.LOG2N(3)) bs ();
    afft_seq #(.LOG2N(3), .BTF_LAT(3)) dut_s (.clk(clk), .rst(rst), .bus(bs));

    afft_seq_if #(.LOG2N(10)) bl ();
    afft_seq #(.LOG2N(10), .BTF_LAT(1)) dut_l (.clk(clk), .rst(rst), .bus(bl));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int p4(int a, int b, int c, int d);
        return (a << 30) | (b << 20) | (c << 10) | d;
    endfunction

    // Expected outputs rel cycles after start was driven, from the stage/group/step rules
    function automatic exp_t model(int l2n, int lat, int rel, int inv);
        exp_t e;
        int n, half, sl, s, off, span, k;
        e = '{default: 0};
        n = 1 << l2n;
        half = n / 2;
        sl = half + 1 + lat;
        if (rel >= 1 && rel <= l2n * sl) begin
            s = (rel - 1) / sl;
            off = (rel - 1) % sl;
            span = n >> (s + 1);
            e.busy = 1;
            e.stage = s;
            if (off < half) begin
                k = off;
                e.rd_en = 1;
                e.a0 = 2 * span * (k / span) + (k % span);
                e.a1 = e.a0 + span;
                e.tw = (k % span) << s;
                e.conj = inv;
            end
            if (off >= 1 && off <= half) e.bfv = 1;
            if (off >= 1 + lat && off < 1 + lat + half) begin
                k = off - 1 - lat;
                e.wr_en = 1;
                e.w0 = 2 * span * (k / span) + (k % span);
                e.w1 = e.w0 + span;
            end
        end else if (rel == l2n * sl + 1) begin
            e.done = 1;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic check_small(input int id, input int rel, input exp_t e);
        chk($sformatf("r%0d_c%0d_ctl", id, rel),
            p4(int'(bs.busy), int'(bs.done), int'(bs.stage), int'(bs.bf_valid)),
            p4(e.busy, e.done, e.stage, e.bfv));
        chk($sformatf("r%0d_c%0d_rd", id, rel),
            p4(int'(bs.rd_en) * 2 + int'(bs.tw_conj), int'(bs.rd_addr0), int'(bs.rd_addr1), int'(bs.tw_addr)),
            p4(e.rd_en * 2 + e.conj, e.a0, e.a1, e.tw));
        chk($sformatf("r%0d_c%0d_wr", id, rel),
            p4(int'(bs.wr_en), int'(bs.wr_addr0), int'(bs.wr_addr1), 0),
            p4(e.wr_en, e.w0, e.w1, 0));
    endtask

    // mode 0: quiet inputs, 1: start pulses at rel 5 and 25, 2: random start/inv noise
    task automatic small_run(input int id, input int inv0, input int rst_rel, input int mode);
        int   last;
        exp_t e;
        rdq.delete();
        wrq.delete();
        last = (rst_rel < 0) ? 25 : rst_rel + 4;
        for (int rel = 0; rel <= last; rel++) begin
            if (rel == 0) begin
                bs.start = 1'b1;
                bs.inv = 1'(inv0);
            end else begin
                if (rst_rel >= 0 && rel == rst_rel) begin
                    rst = 1'b1;
                    bs.start = 1'b1;
                end else begin
                    rst = 1'b0;
                    if (rst_rel >= 0 && rel > rst_rel) bs.start = 1'b0;
                    else if (mode == 1) bs.start = (rel == 5 || rel == 25);
                    else if (mode == 2) bs.start = 1'($urandom_range(0, 1));
                    else bs.start = 1'b0;
                end
                if (rel >= 2) bs.inv = (mode == 2) ? 1'($urandom_range(0, 1)) : ~1'(inv0);
            end
            if (rst_rel >= 0 && rel > rst_rel) e = '{default: 0};
            else e = model(3, 3, rel, inv0);
            check_small(id, rel, e);
            if (bs.rd_en)
                rdq.push_back('{rel, int'(bs.rd_addr0), int'(bs.rd_addr1), int'(bs.tw_addr), int'(bs.tw_conj)});
            if (bs.wr_en)
                wrq.push_back('{rel, int'(bs.wr_addr0), int'(bs.wr_addr1), 0, 0});
            tick();
        end
        rst = 1'b0;
        bs.start = 1'b0;
    endtask

    task automatic check_table(input int id, input int conj);
        chk($sformatf("t%0d_nrd", id), rdq.size(), 12);
        chk($sformatf("t%0d_nwr", id), wrq.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < rdq.size()) begin
                chk($sformatf("t%0d_rd%0d", id, i), p4(rdq[i].cyc, rdq[i].a0, rdq[i].a1, rdq[i].tw),
                    p4(tbl[i].rc, tbl[i].a0, tbl[i].a1, tbl[i].tw));
                chk($sformatf("t%0d_conj%0d", id, i), rdq[i].cj, conj);
            end
            if (i < wrq.size())
                chk($sformatf("t%0d_wr%0d", id, i), p4(wrq[i].cyc, wrq[i].a0, wrq[i].a1, 0),
                    p4(tbl[i].wc, tbl[i].a0, tbl[i].a1, 0));
        end
    endtask

    initial begin
        exp_t e;
        int inv0, rr, gap, nwr, bad, mism, done_rel, s, seen;

        tbl[0]  = '{1, 0, 4, 0, 5};   tbl[1]  = '{2, 1, 5, 1, 6};
        tbl[2]  = '{3, 2, 6, 2, 7};   tbl[3]  = '{4, 3, 7, 3, 8};
        tbl[4]  = '{9, 0, 2, 0, 13};  tbl[5]  = '{10, 1, 3, 2, 14};
        tbl[6]  = '{11, 4, 6, 0, 15}; tbl[7]  = '{12, 5, 7, 2, 16};
        tbl[8]  = '{17, 0, 1, 0, 21}; tbl[9]  = '{18, 2, 3, 0, 22};
        tbl[10] = '{19, 4, 5, 0, 23}; tbl[11] = '{20, 6, 7, 0, 24};

        rst = 1'b1;
        bs.start = 1'b0;
        bs.inv = 1'b0;
        bl.start = 1'b0;
        bl.inv = 1'b0;
        tick();
        tick();
        check_small(0, 0, '{default: 0});
        chk("rst_big", p4(int'(bl.busy), int'(bl.rd_en), int'(bl.wr_en), int'(bl.done)), 0);
        rst = 1'b0;

        // inv=1 captured, inv flipped later, starts at rel 5/25 ignored; next run starts at 26
        small_run(1, 1, -1, 1);
        check_table(1, 1);
        // reset at rel 10 (with start asserted alongside), then a fresh quiet run
        small_run(2, 0, 10, 0);
        small_run(3, 0, -1, 0);
        check_table(3, 0);

        for (int r = 0; r < 6; r++) begin
            inv0 = int'($urandom_range(0, 1));
            rr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : -1;
            small_run(10 + r, inv0, rr, 2);
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
        end

        // N=1024, BTF_LAT=1: coverage of every address once per stage and done timing
        nwr = 0;
        bad = 0;
        mism = 0;
        done_rel = -1;
        seen = 0;
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        for (int rel = 1; rel <= 6000 && seen == 0; rel++) begin
            e = model(10, 1, rel, 0);
            if (int'(bl.wr_en) != e.wr_en || int'(bl.wr_addr0) != e.w0 || int'(bl.wr_addr1) != e.w1 ||
                int'(bl.rd_en) != e.rd_en || int'(bl.rd_addr0) != e.a0 || int'(bl.tw_addr) != e.tw ||
                int'(bl.busy) != e.busy || int'(bl.stage) != e.stage)
                mism++;
            if (bl.wr_en) begin
                nwr++;
                s = (rel - 1) / 514;
                if (s < 10) begin
                    cov[s][int'(bl.wr_addr0)]++;
                    cov[s][int'(bl.wr_addr1)]++;
                end else begin
                    bad++;
                end
            end
            if (bl.done) begin
                done_rel = rel;
                seen = 1;
            end
            tick();
        end
        for (int si = 0; si < 10; si++)
            for (int a = 0; a < 1024; a++)
                if (cov[si][a] != 1) bad++;
        chk("big_done_cycle", done_rel, 10 * (512 + 2) + 1);
        chk("big_writes", nwr, 5120);
        chk("big_cover", bad, 0);
        chk("big_model", mism, 0);
        tick();
        chk("big_idle", p4(int'(bl.busy), int'(bl.done), int'(bl.wr_en), int'(bl.rd_en)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
